// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the core run sequencer.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_TMO
  } run_state_t;

  localparam int OUT_W_DEF         = 10;
  localparam int CNT_W_DEF         = 16;
  localparam int RST_HOLD_DEF      = 4;
  localparam int STABLE_CYCLES_DEF = 8;
  localparam int TIMEOUT_DEF       = 1000;

endpackage

// File: rtl/cpu_run_ctrl_match_detect.sv
// Counts consecutive active cycles where the core out bus equals the completion value.
module run_match_detect
  import cpu_run_pkg::*;
#(
  parameter int OUT_W         = OUT_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [OUT_W-1:0] i_cpu_out,
  input  logic [OUT_W-1:0] i_done_val,
  output logic             o_hit
);

  localparam int MW = $clog2(STABLE_CYCLES + 1);

  logic [MW-1:0] r_match_cnt;
  logic          w_eq;

  assign w_eq = (i_cpu_out == i_done_val);
  // Look-ahead: the counter reaches STABLE_CYCLES at the coming edge.
  assign o_hit = i_en && w_eq && (r_match_cnt == MW'(STABLE_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_match_cnt <= '0;
    end else if (i_clr) begin
      r_match_cnt <= '0;
    end else if (i_en) begin
      if (!w_eq)
        r_match_cnt <= '0;
      else if (r_match_cnt != MW'(STABLE_CYCLES))
        r_match_cnt <= r_match_cnt + MW'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the RISC-V core: reset hold, gated run, completion/watchdog stop.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int OUT_W         = OUT_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int RST_HOLD      = RST_HOLD_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [OUT_W-1:0] i_done_val,
  input  logic [OUT_W-1:0] i_cpu_out,
  output logic             o_cpu_rst,
  output logic             o_cg_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [OUT_W-1:0] o_result
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  run_state_t       r_state;
  logic [HW-1:0]    r_hold_cnt;
  logic             r_cpu_rst;
  logic             r_cg_en;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [OUT_W-1:0] r_result;

  logic w_idle_like;
  logic w_launch;
  logic w_active;
  logic w_hit;
  logic w_tmo_hit;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_TMO);
  assign w_launch    = w_idle_like && i_start;
  assign w_active    = (r_state == ST_RUN) && !i_stop;
  assign w_tmo_hit   = w_active && (r_cycle_cnt == CNT_W'(TIMEOUT - 1));

  run_match_detect #(
    .OUT_W         (OUT_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_match (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_launch),
    .i_en       (w_active),
    .i_cpu_out  (i_cpu_out),
    .i_done_val (i_done_val),
    .o_hit      (w_hit)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_cpu_rst   <= 1'b1;
      r_cg_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_TMO: begin
          if (i_start) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_cpu_rst   <= 1'b1;
            r_cg_en     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HW'(RST_HOLD - 1)) begin
            r_state   <= ST_RUN;
            r_cpu_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        ST_RUN: begin
          r_cg_en <= !i_stop;
          if (w_active)
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          // Completion takes priority over a watchdog expiring on the same cycle.
          if (w_hit) begin
            r_state  <= ST_DONE;
            r_cg_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= i_cpu_out;
          end else if (w_tmo_hit) begin
            r_state   <= ST_TMO;
            r_cg_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_result  <= i_cpu_out;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_rst   = r_cpu_rst;
  assign o_cg_en     = r_cg_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_result    = r_result;

endmodule
